// File: rtl/barrett_pkg.sv
// Shared types and widths for the Barrett constant precompute unit.
package barrett_pkg;

  localparam int MOD_W = 32;
  localparam int K_W   = 6;
  localparam int U_W   = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/barrett_precompute_32b_if.sv
// Start/result bundle between the precompute unit and its requester.
interface barrett_precompute_32b_if;
  import barrett_pkg::*;

  logic             iStart;
  logic [MOD_W-1:0] iMod;
  logic [K_W-1:0]   oK;
  logic [U_W-1:0]   oU;
  logic             oBusy;
  logic             oDone;
  logic             oErr;

  modport master (
    output iStart, iMod,
    input  oK, oU, oBusy, oDone, oErr
  );

  modport slave (
    input  iStart, iMod,
    output oK, oU, oBusy, oDone, oErr
  );
endinterface

// File: rtl/msb_index_32b.sv
// Combinational leading-one detector: index of the highest set bit.
module msb_index_32b
  import barrett_pkg::*;
(
  input  logic [MOD_W-1:0] value,
  output logic [K_W-1:0]   index,
  output logic             zero
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves index unassigned (no latch).
    index = '0;
    for (int i = 0; i < MOD_W; i++) begin
      if (value[i]) index = K_W'(i);
    end
    zero = (value == '0);
  end

endmodule

// File: rtl/barrett_precompute_32b.sv
// Derives K = bitlen(mod) and U = floor(2^(2K)/mod) by restoring division.
// The numerator's leading 1 (bit 2K) is consumed in NORM, where the
// remainder is known to be zero, so DIV only walks bits 2K-1 down to 0.
module barrett_precompute_32b
  import barrett_pkg::*;
(
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  barrett_precompute_32b_if.slave bus
);

  state_t           state;
  logic [MOD_W-1:0] mod_q;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] cnt;
  logic [MOD_W:0]   rem;
  logic [U_W-1:0]   quo;

  logic [K_W-1:0]   msb_idx;
  logic             mod_zero;
  logic [K_W-1:0]   k_norm;

  logic             step_bit;
  logic [MOD_W:0]   step_rem;
  logic [U_W-1:0]   step_quo;
  logic [MOD_W:0]   trial;
  logic             fits;
  logic [MOD_W:0]   rem_nxt;
  logic [U_W-1:0]   quo_nxt;

  msb_index_32b u_msb (
    .value (mod_q),
    .index (msb_idx),
    .zero  (mod_zero)
  );

  assign k_norm = msb_idx + K_W'(1);

  // One restoring-division step; in NORM it starts from r=0, q=0, bit=1.
  always_comb begin
    step_bit = (state == NORM) ? 1'b1 : (cnt == {k_q, 1'b0});
    step_rem = (state == NORM) ? '0 : rem;
    step_quo = (state == NORM) ? '0 : quo;
    trial    = {step_rem[MOD_W-1:0], step_bit};
    fits     = (trial >= {1'b0, mod_q});
    rem_nxt  = fits ? (trial - {1'b0, mod_q}) : trial;
    quo_nxt  = {step_quo[U_W-2:0], fits};
  end

  assign bus.oBusy = (state != IDLE);
  assign bus.oDone = (state == DONE);

  // FSM, datapath and result registers; clear beats enable, enable gates all.
  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state  <= IDLE;
      mod_q  <= '0;
      k_q    <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      bus.oK   <= '0;
      bus.oU   <= '0;
      bus.oErr <= 1'b0;
    end else if (iEn) begin
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            mod_q <= bus.iMod;
            state <= NORM;
          end
        end
        NORM: begin
          if (mod_zero) begin
            bus.oK   <= '0;
            bus.oU   <= '0;
            bus.oErr <= 1'b1;
            state    <= DONE;
          end else begin
            k_q   <= k_norm;
            cnt   <= {k_norm, 1'b0} - CNT_W'(1);
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == '0) begin
            bus.oK   <= k_q;
            bus.oU   <= quo_nxt;
            bus.oErr <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
